// File: rtl/serial_mmio_pkg.sv
// Shared definitions for the serial MMIO responder: register offsets, status bit positions, TX FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package serial_mmio_pkg;

    // Byte offsets within the serial region
    localparam logic [3:0] SER_DATA = 4'h8;
    localparam logic [3:0] SER_STAT = 4'hC;

    // Status register bit positions
    localparam int ST_TXRDY  = 0;
    localparam int ST_RXAV   = 1;
    localparam int ST_RXOVR  = 2;
    localparam int ST_TXDROP = 3;

    // Transmitter pacing FSM
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible at the head on the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop lands on the same edge; pop while empty is ignored.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (flushes pointers and count)
//   i_push, i_push_dat  write strobe and data
//   i_pop               advance the head
//   o_head_dat          current head word (meaningless while o_empty)
//   o_full, o_empty     occupancy flags
//   o_count             words held, DEPTH_LOG2+1 bits so full and empty are distinct
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_dat,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head_dat,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rptr];

    // When full, a same-edge pop frees the slot the push needs; the write lands
    // in the slot being vacated, whose old value has already been read out.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_mmio_slave.sv
// CPU-facing responder for the serial region: RX/TX byte FIFOs, status register, transmitter pacing, RX interrupt.
// Latency: rdata is combinational; a data write reaches tx_start 2 cycles later with an idle transmitter.
// Backpressure: RX overrun and TX-full writes drop the byte and set sticky status bits; tx_busy stalls the TX FSM.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   bus_ce, bus_we, bus_addr       region select, write strobe, byte offset (0x8 data, 0xC status)
//   bus_wdata, bus_rdata           write data ([7:0] used), combinational read data
//   rx_valid, rx_data              received-byte pulse from the UART receiver
//   tx_start, tx_data, tx_busy     transmitter load pulse, byte, and busy handshake
//   irq                            level interrupt while RX data waits
module serial_mmio_slave
    import serial_mmio_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int BUSY_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        irq
);

    localparam int TMO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    // Previous-cycle bus request, used to find the first edge of an access window
    logic       r_win_vld;
    logic       r_win_we;
    logic [3:0] r_win_addr;

    logic       r_rx_ovr;
    logic       r_tx_drop;
    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0] r_tx_data;

    logic w_first;
    logic w_rd_data;
    logic w_wr_data;
    logic w_rd_stat;

    logic       w_rx_push;
    logic       w_rx_pop;
    logic [7:0] w_rx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [RX_DEPTH_LOG2:0] w_rx_count;
    logic       w_rx_ovr_set;

    logic       w_tx_push;
    logic       w_tx_pop;
    logic [7:0] w_tx_head;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic [TX_DEPTH_LOG2:0] w_tx_count;
    logic       w_tx_drop_set;

    logic [3:0] w_status;
    logic       w_unused;

    // Occupancy counts and upper write-data bits are not needed by the register map
    assign w_unused = ^{bus_wdata[31:8], w_rx_count, w_tx_count};

    // A stalled CPU holds ce/we/addr steady; only the first edge of such a run has side effects
    assign w_first   = bus_ce && !(r_win_vld && (r_win_we == bus_we) && (r_win_addr == bus_addr));
    assign w_rd_data = w_first && !bus_we && (bus_addr == SER_DATA);
    assign w_wr_data = w_first &&  bus_we && (bus_addr == SER_DATA);
    assign w_rd_stat = w_first && !bus_we && (bus_addr == SER_STAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_vld  <= 1'b0;
            r_win_we   <= 1'b0;
            r_win_addr <= 4'h0;
        end else begin
            r_win_vld  <= bus_ce;
            r_win_we   <= bus_we;
            r_win_addr <= bus_addr;
        end
    end

    // RX path: a pop on the same edge makes room, so a full FIFO does not overrun then
    assign w_rx_pop      = w_rd_data && !w_rx_empty;
    assign w_rx_push     = rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set  = rx_valid && w_rx_full && !w_rx_pop;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_rx_push),
        .i_push_dat (rx_data),
        .i_pop      (w_rx_pop),
        .o_head_dat (w_rx_head),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty),
        .o_count    (w_rx_count)
    );

    // TX path
    assign w_tx_push     = w_wr_data && !w_tx_full;
    assign w_tx_drop_set = w_wr_data && w_tx_full;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_tx_push),
        .i_push_dat (bus_wdata[7:0]),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_full     (w_tx_full),
        .o_empty    (w_tx_empty),
        .o_count    (w_tx_count)
    );

    // Sticky error bits: a status read clears them, but a fresh event on that edge wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ovr  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            r_rx_ovr  <= w_rx_ovr_set  || (r_rx_ovr  && !w_rd_stat);
            r_tx_drop <= w_tx_drop_set || (r_tx_drop && !w_rd_stat);
        end
    end

    always_comb begin
        w_status            = 4'h0;
        w_status[ST_TXRDY]  = !w_tx_full;
        w_status[ST_RXAV]   = !w_rx_empty;
        w_status[ST_RXOVR]  = r_rx_ovr;
        w_status[ST_TXDROP] = r_tx_drop;
    end

    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            SER_DATA: bus_rdata[7:0] = w_rx_empty ? 8'h00 : w_rx_head;
            SER_STAT: bus_rdata[3:0] = w_status;
            default:  bus_rdata = 32'h0;
        endcase
    end

    assign irq     = !w_rx_empty;
    assign tx_data = r_tx_data;

    // TX pacing FSM. A transmitter that never raises busy is abandoned after
    // BUSY_TIMEOUT cycles in WAIT_BUSY so the queue keeps draining.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        tx_start    = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_tx_empty && !tx_busy) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                tx_start    = 1'b1;
                w_state_nxt = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = TX_WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt = TX_IDLE;
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = TX_IDLE;
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_tmo_cnt <= '0;
            r_tx_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == TX_START) begin
                r_tmo_cnt <= '0;
            end else if (r_state == TX_WAIT_BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            // tx_data is only reloaded here, so it holds from START until the next pop
            if (w_tx_pop) begin
                r_tx_data <= w_tx_head;
            end
        end
    end

endmodule

// File: tb/tb_serial_mmio_slave.sv
// Self-checking bench for serial_mmio_slave: directed steps plus a randomized mixed-traffic phase.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_mmio_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bus_ce = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0] rxq[$];
    int         m_txn;
    logic       m_ovr;
    logic       m_drop;

    // Observed tx_start pulses
    logic [7:0] st_dat[$];
    int         st_cyc[$];

    // Transmitter busy model
    int bm_en = 0;
    int bm_pend = 0;
    int bm_hi = 0;
    int fall_cyc = 0;

    always #5 clk = ~clk;

    serial_mmio_slave dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_ce    (bus_ce),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [3:0] a);
        mdl_rd = 32'h0;
        if (a == 4'h8 && rxq.size() != 0) mdl_rd = {24'h0, rxq[0]};
        else if (a == 4'hC) mdl_rd = {28'h0, m_drop, m_ovr, rxq.size() != 0, m_txn < 16};
    endfunction

    task automatic mdl_clear();
        rxq.delete();
        st_dat.delete();
        st_cyc.delete();
        m_txn = 0;
        m_ovr = 1'b0;
        m_drop = 1'b0;
        bm_pend = 0;
        bm_hi = 0;
        fall_cyc = 0;
    endtask

    // Advance one clock; sample 1 time unit after the edge and run the busy model
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start === 1'b1) begin
            st_dat.push_back(tx_data);
            st_cyc.push_back(cyc);
        end
        if (bm_en != 0) begin
            if (bm_pend != 0) begin
                tx_busy = 1'b1;
                bm_hi = 20;
                bm_pend = 0;
            end else if (bm_hi > 0) begin
                bm_hi--;
                if (bm_hi == 0) begin
                    tx_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
            if (tx_start === 1'b1) bm_pend = 1;
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        tx_busy = 1'b0;
        bus_ce = 1'b0;
        rx_valid = 1'b0;
        bm_en = 0;
        mdl_clear();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        tick();
        if (rxq.size() < 16) rxq.push_back(b);
        else m_ovr = 1'b1;
        rx_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input int hold);
        bus_ce = 1'b1;
        bus_we = 1'b0;
        bus_addr = a;
        for (int h = 0; h < hold; h++) begin
            #1;
            chk($sformatf("rd_%0h_c%0d", a, h), bus_rdata, mdl_rd(a));
            tick();
            if (h == 0) begin
                if (a == 4'h8 && rxq.size() != 0) void'(rxq.pop_front());
                if (a == 4'hC) begin
                    m_ovr = 1'b0;
                    m_drop = 1'b0;
                end
            end
        end
        bus_ce = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_ce = 1'b1;
        bus_we = 1'b1;
        bus_addr = a;
        bus_wdata = d;
        tick();
        if (a == 4'h8) begin
            if (m_txn < 16) m_txn++;
            else m_drop = 1'b1;
        end
        bus_ce = 1'b0;
        bus_we = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] nb;
        logic [7:0] b3[3];

        // ---- 1: reset state ----
        #1;
        rst_n = 1'b0;
        mdl_clear();
        bus_addr = 4'hC;
        #2;
        chk("rst_stat", bus_rdata, 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_txstart", 32'(tx_start), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h0);
        bus_addr = 4'h8;
        #1;
        chk("rst_data", bus_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("t1_no_starts", st_dat.size(), 0);
        bus_read(4'hC, 1);

        // ---- 2: two bytes, stalled read pops once ----
        rx_push(8'h41);
        rx_push(8'h42);
        chk("t2_irq", 32'(irq), 32'h1);
        bus_read(4'hC, 1);
        bus_read(4'h8, 5);
        bus_read(4'h8, 1);
        chk("t2_irq_clear", 32'(irq), 32'h0);
        bus_read(4'hC, 1);

        // ---- 3: overrun, sticky clear, ordered drain ----
        for (int i = 0; i < 17; i++) rx_push(8'($urandom));
        bus_read(4'hC, 1);
        bus_read(4'hC, 1);
        for (int i = 0; i < 16; i++) bus_read(4'h8, 1);
        bus_read(4'hC, 1);

        // ---- 4: paced transmission with a busy transmitter ----
        do_reset();
        bm_en = 1;
        bus_ce = 1'b1;
        bus_we = 1'b1;
        bus_addr = 4'h8;
        bus_wdata = 32'h55;
        tick();
        bus_ce = 1'b0;
        bus_we = 1'b0;
        chk("t4_no_start_c1", 32'(tx_start), 32'h0);
        tick();
        chk("t4_start_c2", 32'(tx_start), 32'h1);
        chk("t4_data0", 32'(tx_data), 32'h55);
        bus_write(4'h8, 32'h66);
        for (int i = 0; i < 200 && st_dat.size() < 2; i++) tick();
        chk("t4_nstarts", st_dat.size(), 2);
        if (st_dat.size() >= 2) begin
            chk("t4_data1", 32'(st_dat[1]), 32'h66);
            chk("t4_fall_after_s0", 32'(fall_cyc > st_cyc[0]), 32'h1);
            chk("t4_s1_after_fall", 32'(st_cyc[1] > fall_cyc), 32'h1);
        end

        // ---- 5: busy never rises, timeout drains queue ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b3[i] = 8'($urandom);
            bus_write(4'h8, {24'h0, b3[i]});
        end
        for (int i = 0; i < 200 && st_dat.size() < 3; i++) tick();
        chk("t5_nstarts", st_dat.size(), 3);
        for (int i = 0; i < 3 && i < st_dat.size(); i++)
            chk($sformatf("t5_data%0d", i), 32'(st_dat[i]), 32'(b3[i]));
        if (st_dat.size() >= 3) begin
            chk("t5_gap01", st_cyc[1] - st_cyc[0], 32'(2 + 15));
            chk("t5_gap12", st_cyc[2] - st_cyc[1], 32'(2 + 15));
        end
        for (int i = 0; i < 40; i++) tick();
        chk("t5_no_extra", st_dat.size(), 3);

        // ---- randomized mixed traffic, transmitter held busy ----
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    rx_push(8'($urandom));
                2:       bus_read(4'h8, $urandom_range(1, 3));
                3, 4:    bus_write(4'h8, $urandom);
                5:       bus_read(4'hC, 1);
                6:       bus_read(4'($urandom_range(0, 7)), 1);
                default: bus_write(4'hC, $urandom);
            endcase
            chk("rnd_irq", 32'(irq), 32'(rxq.size() != 0));
        end
        bus_read(4'hC, 1);

        // ---- 6: same-edge push and pop, full then empty ----
        do_reset();
        for (int i = 0; i < 16; i++) rx_push(8'($urandom));
        nb = 8'($urandom);
        bus_ce = 1'b1;
        bus_we = 1'b0;
        bus_addr = 4'h8;
        rx_valid = 1'b1;
        rx_data = nb;
        #1;
        chk("t6_full_rd", bus_rdata, mdl_rd(4'h8));
        tick();
        void'(rxq.pop_front());
        rxq.push_back(nb);
        rx_valid = 1'b0;
        bus_ce = 1'b0;
        tick();
        bus_read(4'hC, 1);
        for (int i = 0; i < 16; i++) bus_read(4'h8, 1);
        bus_read(4'hC, 1);

        nb = 8'($urandom);
        bus_ce = 1'b1;
        bus_addr = 4'h8;
        rx_valid = 1'b1;
        rx_data = nb;
        #1;
        chk("t6_empty_rd", bus_rdata, 32'h0);
        tick();
        rxq.push_back(nb);
        rx_valid = 1'b0;
        bus_ce = 1'b0;
        tick();
        bus_read(4'hC, 1);
        bus_read(4'h8, 1);
        chk("t6_empty_irq", 32'(irq), 32'h0);

        // ---- 6: reset while tx_start is high drops it immediately ----
        bus_write(4'h8, {24'h0, 8'($urandom)});
        chk("t6_start_hi", 32'(tx_start), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_start_async", 32'(tx_start), 32'h0);
        mdl_clear();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- 6: reset during WAIT_DONE flushes FIFOs and idles the FSM ----
        bus_write(4'h8, {24'h0, 8'($urandom)});
        tx_busy = 1'b1;
        tick();
        tick();
        tick();
        rx_push(8'($urandom));
        rx_push(8'($urandom));
        bus_write(4'h8, {24'h0, 8'($urandom)});
        bus_write(4'h8, {24'h0, 8'($urandom)});
        chk("t6_irq_pre", 32'(irq), 32'h1);
        #2;
        rst_n = 1'b0;
        tx_busy = 1'b0;
        mdl_clear();
        bus_addr = 4'h8;
        #1;
        chk("t6_rst_irq", 32'(irq), 32'h0);
        chk("t6_rst_data", bus_rdata, 32'h0);
        bus_addr = 4'hC;
        #1;
        chk("t6_rst_stat", bus_rdata, 32'h1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_flushed", st_dat.size(), 0);
        nb = 8'($urandom);
        bus_write(4'h8, {24'h0, nb});
        chk("t6_post_start", 32'(tx_start), 32'h1);
        chk("t6_post_data", 32'(tx_data), 32'(nb));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
